rx_byte_fifo: RTL and testbench
===============================

Name: rx_byte_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle done strobe and stores it in a circular FIFO. Bytes are presented to the consumer through a first-word-fall-through valid/ready read port. Bytes that arrive while the FIFO is full are dropped and flagged with a sticky overflow error.

Parameters:
DEPTH, 8, number of byte entries; must be a power of 2 and at least 2
WIDTH, 8, data width in bits; matches the receiver byte width

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
byteIn  input  WIDTH  received byte from the UART receiver; valid while doneIn=1
doneIn  input  1  receiver done strobe; each cycle it is high is one write request
rdData  output  WIDTH  head-of-FIFO byte; valid when rdValid=1
rdValid  output  1  FIFO non-empty
rdReady  input  1  consumer accepts rdData this cycle
count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
overflow  output  1  sticky: a write was dropped because the FIFO was full
overflowClear  input  1  clears overflow

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - count=0, empty=1, full=0, rdValid=0, rdData=0, overflow=0.
  - Write and read pointers are set to 0.
  - Storage contents are not reset.
- Pointers:
  - wrPtr and rdPtr are each $clog2(DEPTH)+1 bits wide and wrap naturally modulo 2*DEPTH.
  - The storage index is the low $clog2(DEPTH) bits.
  - count = wrPtr - rdPtr (modular subtraction).
  - full and empty are derived from count and are combinational from registered state.
- Write event:
  - Occurs when doneIn=1 at a posedge and (full=0 or a pop occurs in the same cycle).
  - byteIn is stored at wrPtr and wrPtr increments.
  - No edge detection is performed: doneIn held high for k cycles produces k writes.
- Pop event:
  - Occurs when rdValid=1 and rdReady=1 at a posedge; rdPtr increments.
  - rdReady while empty is ignored, with no pointer change.
- Read port:
  - rdValid = !empty.
  - rdData = storage[rdPtr] when non-empty, otherwise 0. The value is combinational from registered state.
- Latency: a byte written at edge N appears on rdData with rdValid=1 in the cycle immediately after edge N (one cycle from doneIn to rdValid).
- Simultaneous write and pop:
  - Both take effect and count is unchanged.
  - This holds at full as well: the write is accepted because the pop frees a slot.
  - At empty there is no pop (rdValid=0), so only the write occurs and count goes 0->1.
- Overflow:
  - Occurs when doneIn=1, full=1 and no pop in that cycle.
  - The byte is discarded, the pointers are unchanged, and overflow is set to 1 at that edge.
  - Stored data is never overwritten.
- overflowClear:
  - overflowClear=1 clears overflow at the next edge.
  - If an overflow event occurs in the same cycle, set wins and overflow stays 1.
- Ordering: strict FIFO order and no reordering. Wrap-around of the pointers past index DEPTH-1 is seamless.
- Reset mid-operation: rst=1 at any edge discards all contents, pointers and overflow, regardless of doneIn, rdReady or overflowClear in that cycle. rst has priority over all other inputs.

Test Plan:
- Basic latency: after reset, pulse doneIn for 1 cycle with byteIn=8'hA5, rdReady=0 -> next cycle rdValid=1, rdData=8'hA5, count=1, empty=0. Then rdReady=1 for 1 cycle -> rdValid=0, rdData=0, count=0.
- Fill and wrap: write 8'h00..8'h07 (DEPTH=8) -> full=1, count=8. Pop 3 and write 8'h08..8'h0A. Drain all -> output order is 03,04,05,06,07,08,09,0A, with empty=1 at the end.
- Overflow: FIFO full, write 8'hFF with rdReady=0 -> overflow=1, count=8, contents unchanged. Pulse overflowClear -> overflow=0. overflowClear coincident with a new overflow event -> overflow stays 1.
- Simultaneous at full: FIFO full with head 8'h10; doneIn=1, byteIn=8'h55, rdReady=1 in the same cycle -> count stays 8, 8'h55 becomes the last entry, and the next head is the second-oldest byte.
- Back-to-back: doneIn held high 3 cycles with byteIn 8'h01,8'h02,8'h03 and rdReady=1 throughout -> 3 writes, consumer receives 01,02,03 in order, count never exceeds 1.
- Reset mid-operation: count=5 and overflow=1; assert rst for 1 cycle while doneIn=1 and rdReady=1 -> next cycle count=0, empty=1, rdValid=0, rdData=0, overflow=0, and the byte offered during reset is not stored.

Source files
------------

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo
// ------------
// Receive-side byte buffer placed directly after the UART receiver. Every
// cycle doneIn is high is one write request for byteIn. Bytes sit in a
// circular buffer and are offered to the consumer through a
// first-word-fall-through valid/ready port. A byte that arrives while the
// buffer is full, with no pop in the same cycle, is discarded. That event
// raises the sticky overflow flag.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   rst            synchronous active-high reset (pointers, overflow)
//   byteIn         received byte, qualified by doneIn
//   doneIn         receiver done strobe, one write request per high cycle
//   rdData         head byte, forced to 0 while empty
//   rdValid        buffer is non-empty
//   rdReady        consumer takes rdData this cycle
//   count          number of stored bytes, 0..DEPTH
//   full / empty   count == DEPTH / count == 0
//   overflow       sticky: a byte was dropped because the buffer was full
//   overflowClear  clears overflow at the next edge (a new drop wins)

module rx_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           byteIn,
  input  logic                       doneIn,
  output logic [WIDTH-1:0]           rdData,
  output logic                       rdValid,
  input  logic                       rdReady,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       overflowClear
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  // Pointers carry one extra bit so that full and empty stay distinct.
  // They wrap modulo 2*DEPTH through plain unsigned overflow.
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             pop;
  logic             wr_en;
  logic             ovf_evt;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // Status and read port: combinational from registered state
  always_comb begin
    count   = wr_ptr - rd_ptr;
    full    = (count == DEPTH_P);
    empty   = (count == '0);
    rdValid = !empty;
    wr_idx  = wr_ptr[AW-1:0];
    rd_idx  = rd_ptr[AW-1:0];
    rdData  = empty ? '0 : mem[rd_idx];
  end

  // A pop in the same cycle frees the head slot. That lets a write at full
  // proceed. The slot being written is then the one the pop vacates.
  always_comb begin
    pop     = rdValid && rdReady;
    wr_en   = doneIn && (!full || pop);
    ovf_evt = doneIn && full && !pop;
  end

  // Control state: pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      // Set has priority over clear
      if (ovf_evt)            overflow <= 1'b1;
      else if (overflowClear) overflow <= 1'b0;
    end
  end

  // Storage: contents are not reset. Writes are gated off during reset, so a
  // byte offered in that cycle is never captured.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= byteIn;
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
module tb_rx_byte_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] byteIn;
  logic             doneIn;
  logic [WIDTH-1:0] rdData;
  logic             rdValid;
  logic             rdReady;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             overflowClear;

  int checks = 0;
  int failures = 0;

  rx_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .byteIn(byteIn), .doneIn(doneIn),
    .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .overflowClear(overflowClear)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    doneIn = 0; rdReady = 0; overflowClear = 0; rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; doneIn = 0; rdReady = 0; overflowClear = 0; byteIn = 0;
    tick(); tick();
    rst = 0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL reset_rdValid got=%b exp=0", rdValid); end
    checks++; if (rdData !== 8'h00) begin failures++; $display("FAIL reset_rdData got=%h exp=00", rdData); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_latency();
    doneIn = 1; byteIn = 8'hA5;
    tick();
    doneIn = 0;
    checks++; if (rdValid !== 1'b1) begin failures++; $display("FAIL lat_rdValid got=%b exp=1", rdValid); end
    checks++; if (rdData !== 8'hA5) begin failures++; $display("FAIL lat_rdData got=%h exp=a5", rdData); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL lat_count got=%0d exp=1", count); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL lat_empty got=%b exp=0", empty); end
    rdReady = 1;
    tick();
    rdReady = 0;
    checks++; if (rdValid !== 1'b0) begin failures++; $display("FAIL lat_pop_rdValid got=%b exp=0", rdValid); end
    checks++; if (rdData !== 8'h00) begin failures++; $display("FAIL lat_pop_rdData got=%h exp=00", rdData); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL lat_pop_count got=%0d exp=0", count); end
    // rdReady while empty must not move the read pointer
    rdReady = 1;
    tick();
    rdReady = 0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      doneIn = 1; byteIn = 8'(i);
      tick();
    end
    doneIn = 0;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", count); end
    for (int i = 0; i < 3; i++) begin
      exp = 8'(i);
      checks++; if (rdData !== exp) begin failures++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, rdData, exp); end
      rdReady = 1;
      tick();
      rdReady = 0;
    end
    for (int i = 8; i < 11; i++) begin
      doneIn = 1; byteIn = 8'(i);
      tick();
    end
    doneIn = 0;
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL wrap_refill_count got=%0d exp=8", count); end
    for (int i = 3; i < 11; i++) begin
      exp = 8'(i);
      checks++; if (rdData !== exp || rdValid !== 1'b1) begin failures++; $display("FAIL wrap_drain%0d got=%h v=%b exp=%h", i, rdData, rdValid, exp); end
      rdReady = 1;
      tick();
      rdReady = 0;
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      doneIn = 1; byteIn = 8'h20 + 8'(i);
      tick();
    end
    doneIn = 1; byteIn = 8'hFF;
    tick();
    doneIn = 0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
    checks++; if (rdData !== 8'h20) begin failures++; $display("FAIL ovf_head got=%h exp=20", rdData); end
    overflowClear = 1;
    tick();
    overflowClear = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    overflowClear = 1; doneIn = 1; byteIn = 8'hEE;
    tick();
    overflowClear = 0; doneIn = 0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    overflowClear = 1;
    tick();
    overflowClear = 0;
    for (int i = 0; i < 8; i++) begin
      exp = 8'h20 + 8'(i);
      checks++; if (rdData !== exp) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, rdData, exp); end
      rdReady = 1;
      tick();
      rdReady = 0;
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simul_full();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      doneIn = 1; byteIn = 8'h10 + 8'(i);
      tick();
    end
    doneIn = 1; byteIn = 8'h55; rdReady = 1;
    tick();
    doneIn = 0; rdReady = 0;
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL simul_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL simul_overflow got=%b exp=0", overflow); end
    checks++; if (rdData !== 8'h11) begin failures++; $display("FAIL simul_head got=%h exp=11", rdData); end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 8'h55 : 8'h11 + 8'(i);
      checks++; if (rdData !== exp) begin failures++; $display("FAIL simul_drain%0d got=%h exp=%h", i, rdData, exp); end
      rdReady = 1;
      tick();
      rdReady = 0;
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    rdReady = 1;
    for (int i = 1; i <= 3; i++) begin
      doneIn = 1; byteIn = 8'(i);
      tick();
      exp = 8'(i);
      checks++; if (rdData !== exp || count !== 4'd1) begin failures++; $display("FAIL b2b_%0d got=%h cnt=%0d exp=%h cnt=1", i, rdData, count, exp); end
    end
    doneIn = 0;
    tick();
    rdReady = 0;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL b2b_final_count got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      doneIn = 1; byteIn = 8'h30 + 8'(i);
      tick();
    end
    doneIn = 0;
    rdReady = 1;
    tick(); tick(); tick();
    rdReady = 0;
    checks++; if (count !== 4'd5 || overflow !== 1'b1) begin failures++; $display("FAIL rstmid_pre cnt=%0d ovf=%b exp cnt=5 ovf=1", count, overflow); end
    rst = 1; doneIn = 1; byteIn = 8'h99; rdReady = 1;
    tick();
    idle();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || rdValid !== 1'b0) begin failures++; $display("FAIL rstmid_empty got e=%b v=%b exp e=1 v=0", empty, rdValid); end
    checks++; if (rdData !== 8'h00) begin failures++; $display("FAIL rstmid_rdData got=%h exp=00", rdData); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
    tick();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rstmid_nostore got=%0d exp=0", count); end
  endtask

  initial begin
    idle();
    byteIn = 0;
    test_reset();
    test_latency();
    test_fill_wrap();
    test_overflow();
    test_simul_full();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
